mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: XLEN, 32, datapath and address width.
REQ-002 Port: i_clk  in  1  clock, all state updates on rising edge.
REQ-003 Port: i_rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: i_valid  in  1  execute stage presents an instruction.
REQ-005 Port: o_ready  out  1  block accepts the instruction this cycle.
REQ-006 Port: i_instr  in  XLEN  instruction word.
REQ-007 Port: i_alu  in  XLEN  ALU result: effective address for load/store, result otherwise.
REQ-008 Port: i_rs2  in  XLEN  store data.
REQ-009 Ports: o_mem_req 1, o_mem_we 1, o_mem_addr XLEN, o_mem_wdata XLEN, o_mem_be 4 (out); i_mem_ack 1, i_mem_rdata XLEN (in); data-memory port.
REQ-010 Ports: o_wb_valid 1, o_wb_instr XLEN, o_wb_data XLEN (out); result to the write-back stage.
REQ-011 Port: o_misalign  out  1  one-cycle pulse on a misaligned access.

Function
REQ-012 FSM states IDLE, ACCESS, RESP; o_ready shall be 1 only in IDLE.
REQ-013 Accept = i_valid & o_ready; i_instr, i_alu and i_rs2 are captured on accept.
REQ-014 Accepted non-memory opcode (not LOAD 0000011 / STORE 0100011): state stays IDLE; o_wb_valid=1 next cycle with o_wb_data=i_alu (1-cycle latency).
REQ-015 Accepted load/store: IDLE->ACCESS; o_mem_req=1 from the next cycle, with address/we/be/wdata held stable until i_mem_ack.
REQ-016 ACCESS with i_mem_ack=1 -> RESP, o_mem_req drops next cycle; RESP -> IDLE unconditionally; o_wb_valid=1 during RESP only.
REQ-017 o_mem_addr = {addr[XLEN-1:2],2'b00}; o_mem_we=1 for STORE only.
REQ-018 Byte enables: funct3 000 -> 0001<<addr[1:0]; 001 -> 0011<<{addr[1],1'b0}; 010 -> 1111; other funct3 values are handled as 010.
REQ-019 Store wdata: SB replicates rs2[7:0] x4; SH replicates rs2[15:0] x2; SW uses rs2.
REQ-020 Load data = i_mem_rdata >> (8*addr[1:0]), then: 000 LB sign-extend 8 bits, 001 LH sign-extend 16, 100 LBU zero-extend 8, 101 LHU zero-extend 16, other word; the result is registered into o_wb_data on ack.
REQ-021 For a store, o_wb_data=0 in RESP; o_wb_instr always carries the captured instruction, which downstream uses to suppress the register write.
REQ-022 i_mem_ack outside ACCESS shall be ignored; i_valid outside IDLE shall not be captured.
REQ-023 Outside their valid cycles, o_wb_valid=0 and o_mem_req=0; other outputs hold their last value.

Reset
REQ-024 While i_rst=0, the FSM shall be IDLE and all outputs 0 except o_ready=1; assertion mid-ACCESS aborts the access immediately, with no write-back.

Configuration
REQ-025 With MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or word with addr[1:0]!=0, pulses o_misalign on the accept+1 cycle, issues no memory request, and goes straight to RESP with o_wb_data=0.
REQ-026 Without MISALIGN_TRAP_EN: o_misalign is tied 0 and misaligned accesses proceed with the REQ-018/020 lane arithmetic (lanes truncate).

Structure
REQ-027 Opcode constants LOAD/STORE, funct3 codes, XLEN and the FSM state encoding belong in the shared define header.
REQ-028 One sub-module, mem_align, is natural: combinational byte-enable, store-replication and load-extension logic.

Verification
REQ-029 ADD, alu=0x1234 -> o_wb_valid 1 cycle later, o_wb_data=0x1234, o_mem_req never asserted.
REQ-030 LB addr=0x103, rdata=0x80FF_FFFF, ack after 3 cycles -> be=1000, addr=0x100, wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-031 SH addr=0x202, rs2=0xDEAD_BEEF -> we=1, be=1100, wdata=0xBEEF_BEEF, wb_data=0.
REQ-032 i_rst pulsed low mid-ACCESS -> o_mem_req=0 at once, no o_wb_valid, o_ready=1 after release.
REQ-033 LW addr=0x101 with MISALIGN_TRAP_EN -> o_misalign pulse, no o_mem_req; without the macro -> be=1111, addr=0x100.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: data width, opcode and
// funct3 codes, FSM state encoding and the misalignment rule.
package mem_access_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Byte accesses never misalign, halfwords need addr[0]=0, everything
    // else is treated as a word and needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic is_half;
        logic is_byte;
        if (opcode == OPC_LOAD) begin
            is_half = (funct3 == F3_H) || (funct3 == F3_HU);
            is_byte = (funct3 == F3_B) || (funct3 == F3_BU);
        end else begin
            is_half = (funct3 == F3_H);
            is_byte = (funct3 == F3_B);
        end
        if (is_byte)
            return 1'b0;
        else if (is_half)
            return addr_lo[0];
        else
            return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-stage, data-memory and write-back signals of the memory-access
// stage. The slave modport is the stage itself; master is its environment.
interface mem_access_if;
    import mem_access_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_instr;
    logic [XLEN-1:0] i_alu;
    logic [XLEN-1:0] i_rs2;

    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_be;
    logic            i_mem_ack;
    logic [XLEN-1:0] i_mem_rdata;

    logic            o_wb_valid;
    logic [XLEN-1:0] o_wb_instr;
    logic [XLEN-1:0] o_wb_data;

    logic            o_misalign;

    modport slave (
        input  i_valid, i_instr, i_alu, i_rs2, i_mem_ack, i_mem_rdata,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output o_wb_valid, o_wb_instr, o_wb_data, o_misalign
    );

    modport master (
        output i_valid, i_instr, i_alu, i_rs2, i_mem_ack, i_mem_rdata,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  o_wb_valid, o_wb_instr, o_wb_data, o_misalign
    );

endinterface

// File: rtl/mem_access_align.sv
// mem_align: combinational lane logic -- byte enables, store data
// replication and load shift/extension, all selected by funct3.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] byte_rep;
    logic [XLEN-1:0] half_rep;
    logic [XLEN-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < XLEN / 8; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = rs2[7:0];
        end
        for (gi = 0; gi < XLEN / 16; gi++) begin : g_half_rep
            assign half_rep[gi*16 +: 16] = rs2[15:0];
        end
    endgenerate

    // Addressed byte moves down to lane 0; bytes past the word top fall off.
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Store side: enables and replicated data; unknown widths act as word.
    always_comb begin
        be    = 4'b1111;
        wdata = rs2;
        case (funct3)
            F3_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = byte_rep;
            end
            F3_H: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = half_rep;
            end
            default: ;
        endcase
    end

    // Load side: sign or zero extension of the shifted read data.
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage between execute and write-back. Non-memory
// instructions pass through in one cycle; loads/stores run IDLE->ACCESS->RESP.
// Build option MISALIGN_TRAP_EN: misaligned accesses skip memory and pulse
// o_misalign instead of using truncated lanes.
module mem_access
    import mem_access_pkg::*;
(
    input logic         i_clk,
    input logic         i_rst,
    mem_access_if.slave bus
);

    state_t          state_reg, state_next;
    logic            ready, mem_req, resp;
    logic            accept, is_mem, trap;
    logic [6:0]      opcode;

    logic [XLEN-1:0] instr_reg;
    logic [1:0]      addr_lo_reg;
    logic            alu_wb_reg;
    logic            mem_we_reg;
    logic [XLEN-1:0] mem_addr_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic [3:0]      mem_be_reg;
    logic [XLEN-1:0] wb_data_reg;

    logic [2:0]      align_funct3;
    logic [1:0]      align_addr_lo;
    logic [3:0]      align_be;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;

    assign opcode = bus.i_instr[6:0];
    assign is_mem = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign accept = bus.i_valid & ready;

    // Lane logic sees the incoming instruction while idle (store setup) and
    // the captured one afterwards (load extension on ack).
    assign align_funct3  = (state_reg == ST_IDLE) ? bus.i_instr[14:12] : instr_reg[14:12];
    assign align_addr_lo = (state_reg == ST_IDLE) ? bus.i_alu[1:0]     : addr_lo_reg;

    mem_align u_align (
        .funct3    (align_funct3),
        .addr_lo   (align_addr_lo),
        .rs2       (bus.i_rs2),
        .rdata     (bus.i_mem_rdata),
        .be        (align_be),
        .wdata     (align_wdata),
        .load_data (align_load)
    );

`ifdef MISALIGN_TRAP_EN
    logic misalign_reg;

    assign trap = is_mem && is_misaligned(opcode, bus.i_instr[14:12], bus.i_alu[1:0]);

    // One-cycle pulse in the cycle after a trapped accept.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            misalign_reg <= 1'b0;
        else
            misalign_reg <= accept && trap;
    end

    assign bus.o_misalign = misalign_reg;
`else
    assign trap           = 1'b0;
    assign bus.o_misalign = 1'b0;
`endif

    // State register; reset drops any access in flight immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next state and per-state handshake outputs.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        mem_req    = 1'b0;
        resp       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.i_valid && is_mem)
                    state_next = trap ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                if (bus.i_mem_ack)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                resp       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture on accept, hold the memory request fields, register results.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            instr_reg     <= '0;
            addr_lo_reg   <= '0;
            alu_wb_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            wb_data_reg   <= '0;
        end else begin
            alu_wb_reg <= accept && !is_mem;
            if (accept) begin
                instr_reg   <= bus.i_instr;
                addr_lo_reg <= bus.i_alu[1:0];
                if (!is_mem) begin
                    wb_data_reg <= bus.i_alu;
                end else if (trap) begin
                    wb_data_reg <= '0;
                end else begin
                    mem_we_reg    <= (opcode == OPC_STORE);
                    mem_addr_reg  <= {bus.i_alu[XLEN-1:2], 2'b00};
                    mem_wdata_reg <= align_wdata;
                    mem_be_reg    <= align_be;
                end
            end
            if ((state_reg == ST_ACCESS) && bus.i_mem_ack)
                wb_data_reg <= mem_we_reg ? '0 : align_load;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_we    = mem_we_reg;
    assign bus.o_mem_addr  = mem_addr_reg;
    assign bus.o_mem_wdata = mem_wdata_reg;
    assign bus.o_mem_be    = mem_be_reg;
    assign bus.o_wb_valid  = resp | alu_wb_reg;
    assign bus.o_wb_instr  = instr_reg;
    assign bus.o_wb_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by random
// load/store/ALU transactions checked against an arithmetic lane model.
module tb_mem_access;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   trap_en;

    mem_access_if bus();

    mem_access dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] make_instr(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r        = $urandom;
        r[6:0]   = opc;
        r[14:12] = f3;
        return r;
    endfunction

    // Access width in bytes as the ISA defines it for each opcode/funct3.
    function automatic int width_of(input logic [31:0] instr);
        logic [2:0] f3;
        f3 = instr[14:12];
        if (instr[6:0] == LOAD_OP) begin
            if (f3 == 3'd0 || f3 == 3'd4) return 1;
            if (f3 == 3'd1 || f3 == 3'd5) return 2;
            return 4;
        end
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input int off);
        int base;
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) begin
            base = off - (off % 2);
            return 4'(3 << base);
        end
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        longint unsigned u;
        u = rs2;
        if (f3 == 3'd0) return 32'((u % 256) * 64'h0101_0101);
        if (f3 == 3'd1) return 32'((u % 65536) * 64'h0001_0001);
        return rs2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        longint unsigned u;
        longint          v;
        u = rdata;
        u = u / (64'd1 << (8 * off));
        case (f3)
            3'd0: begin v = longint'(u % 256);   if (v >= 128)   v -= 256;   end
            3'd1: begin v = longint'(u % 65536); if (v >= 32768) v -= 65536; end
            3'd4: v = longint'(u % 256);
            3'd5: v = longint'(u % 65536);
            default: v = longint'(u);
        endcase
        return v[31:0];
    endfunction

    // One complete transaction from the idle state back to the idle state.
    task automatic run_txn(input logic [31:0] instr, input logic [31:0] alu,
                           input logic [31:0] rs2, input logic [31:0] rdata, input int delay);
        bit          is_load, is_store, mem, trapped;
        int          off;
        logic [2:0]  f3;
        logic [31:0] exp_wb;
        is_load  = (instr[6:0] == LOAD_OP);
        is_store = (instr[6:0] == STORE_OP);
        mem      = is_load || is_store;
        off      = int'(alu % 4);
        f3       = instr[14:12];
        trapped  = mem && trap_en && ((alu % width_of(instr)) != 0);
        exp_wb   = is_store ? 32'd0 : model_load(f3, off, rdata);

        check("ready_before", bus.o_ready, 1);
        bus.i_valid = 1'b1;
        bus.i_instr = instr;
        bus.i_alu   = alu;
        bus.i_rs2   = rs2;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_instr = $urandom;
        bus.i_alu   = $urandom;
        bus.i_rs2   = $urandom;

        if (!mem) begin
            check("alu_wb_valid", bus.o_wb_valid, 1);
            check("alu_wb_data", bus.o_wb_data, alu);
            check("alu_wb_instr", bus.o_wb_instr, instr);
            check("alu_mem_req", bus.o_mem_req, 0);
            @(negedge clk);
            check("alu_wb_valid_drop", bus.o_wb_valid, 0);
            check("alu_mem_req_after", bus.o_mem_req, 0);
        end else if (trapped) begin
            check("trap_pulse", bus.o_misalign, 1);
            check("trap_mem_req", bus.o_mem_req, 0);
            check("trap_wb_valid", bus.o_wb_valid, 1);
            check("trap_wb_data", bus.o_wb_data, 0);
            @(negedge clk);
            check("trap_pulse_drop", bus.o_misalign, 0);
            check("trap_wb_valid_drop", bus.o_wb_valid, 0);
            check("trap_ready", bus.o_ready, 1);
        end else begin
            check("mem_req", bus.o_mem_req, 1);
            check("mem_addr", bus.o_mem_addr, alu & 32'hFFFF_FFFC);
            check("mem_we", bus.o_mem_we, is_store);
            check("mem_be", bus.o_mem_be, model_be(f3, off));
            if (is_store) check("mem_wdata", bus.o_mem_wdata, model_wdata(f3, rs2));
            check("mem_ready_busy", bus.o_ready, 0);
            check("mem_misalign", bus.o_misalign, 0);
            repeat (delay) begin
                bus.i_valid = 1'b1;
                @(negedge clk);
            end
            bus.i_valid = 1'b0;
            check("mem_req_held", bus.o_mem_req, 1);
            check("mem_addr_held", bus.o_mem_addr, alu & 32'hFFFF_FFFC);
            check("mem_wb_idle", bus.o_wb_valid, 0);
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = rdata;
            @(negedge clk);
            bus.i_mem_ack   = 1'b0;
            bus.i_mem_rdata = $urandom;
            check("resp_wb_valid", bus.o_wb_valid, 1);
            check("resp_mem_req", bus.o_mem_req, 0);
            check("resp_wb_data", bus.o_wb_data, exp_wb);
            check("resp_wb_instr", bus.o_wb_instr, instr);
            @(negedge clk);
            check("resp_wb_drop", bus.o_wb_valid, 0);
            check("resp_ready", bus.o_ready, 1);
        end
    endtask

    initial begin
        logic [6:0]  nonmem_ops [4];
        logic [31:0] instr, alu;
        logic [2:0]  f3;
        int          kind;

        nonmem_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011};
`ifdef MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        n_cmp = 0;
        n_bad = 0;
        rst             = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_instr     = '0;
        bus.i_alu       = '0;
        bus.i_rs2       = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1);
        check("rst_mem_req", bus.o_mem_req, 0);
        check("rst_wb_valid", bus.o_wb_valid, 0);
        check("rst_wb_data", bus.o_wb_data, 0);
        check("rst_wb_instr", bus.o_wb_instr, 0);
        check("rst_mem_addr", bus.o_mem_addr, 0);
        check("rst_mem_be", bus.o_mem_be, 0);
        check("rst_misalign", bus.o_misalign, 0);
        rst = 1'b1;
        @(negedge clk);

        // ADD pass-through
        run_txn(32'h00B5_0533, 32'h0000_1234, 32'h0, 32'h0, 0);
        // LB / LBU at byte 3, ack after 3 cycles
        run_txn(make_instr(LOAD_OP, 3'd0), 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3);
        run_txn(make_instr(LOAD_OP, 3'd4), 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3);
        // SH at upper half
        run_txn(make_instr(STORE_OP, 3'd1), 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 1);
        // LW misaligned
        run_txn(make_instr(LOAD_OP, 3'd2), 32'h0000_0101, 32'h0, 32'h1122_3344, 0);

        // Reset in the middle of an access
        bus.i_valid = 1'b1;
        bus.i_instr = make_instr(LOAD_OP, 3'd2);
        bus.i_alu   = 32'h0000_0300;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("abort_req_before", bus.o_mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_req_drop", bus.o_mem_req, 0);
        check("abort_ready", bus.o_ready, 1);
        check("abort_wb_data", bus.o_wb_data, 0);
        @(negedge clk);
        rst = 1'b1;
        // Ack while idle is ignored
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
        check("abort_no_wb", bus.o_wb_valid, 0);
        check("idle_ack_ready", bus.o_ready, 1);
        check("idle_ack_req", bus.o_mem_req, 0);
        check("idle_ack_wb_data", bus.o_wb_data, 0);
        @(negedge clk);
        check("idle_ack_no_wb", bus.o_wb_valid, 0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            alu  = $urandom;
            if (kind == 0) begin
                instr = make_instr(nonmem_ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)));
            end else if (kind == 1) begin
                f3    = 3'($urandom_range(0, 7));
                instr = make_instr(LOAD_OP, f3);
            end else begin
                f3    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                instr = make_instr(STORE_OP, f3);
            end
            run_txn(instr, alu, $urandom, $urandom, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
